// File: rtl/spi_tx_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared types and constants for the SPI transmit path. The state
//           encoding is used by the serializer. The SPI mode constants are
//           also used by the upstream TX control unit.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4
  } spi_tx_state_t;

  // SPI mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage
`default_nettype wire

// File: rtl/spi_tx_shifter_half_tick.sv
`default_nettype none
// ============================================================================
// Module  : spi_half_tick
// Purpose : Free-running divider that emits a one-cycle tick every HALF
//           system clocks. The counter runs 0..HALF-1 and wraps. i_clear holds
//           it at zero, so the first tick after clear arrives HALF cycles later.
// Ports   : i_clock    system clock
//           i_reset_n  asynchronous active-low reset
//           i_clear    synchronous clear (held while the serializer is idle)
//           o_tick     high on the last cycle of each HALF-cycle window
// Rev     : 1.0  initial release
// ============================================================================
module spi_half_tick #(
  parameter int HALF = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_tick
);

  // Keep at least one bit so HALF=1 degenerates to a constant-zero counter
  // whose terminal count is reached every cycle.
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(HALF - 1);

  logic [CW-1:0] r_count;
  logic          w_term;

  assign w_term = (r_count == C_TERM);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear || w_term) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = w_term;

endmodule
`default_nettype wire

// File: rtl/spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_shifter
// Purpose : SPI mode-0 master transmit serializer. Accepts a one-cycle send
//           strobe with a parallel word. Drives CS_n/SCLK/MOSI through the
//           phases LEAD (CS setup), SHIFT (DATA_WIDTH SCLK periods) and TRAIL
//           (CS hold). Then pulses done for one cycle. A new send is accepted
//           in that done cycle, which gives one CS-high cycle between frames.
// Ports   : i_clock    system clock, rising edge
//           i_reset_n  asynchronous active-low reset
//           i_send     start strobe, honoured only in IDLE or DONE
//           i_data     payload, captured when i_send is accepted
//           o_sclk     SPI clock, idles low
//           o_mosi     serial data, changes only while o_sclk is low
//           o_cs_n     chip select, active low
//           o_busy     frame in progress (LEAD/SHIFT/TRAIL)
//           o_done     one-cycle frame-complete pulse
// Rev     : 1.0  initial release
// ============================================================================
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_send,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] C_LAST_BIT = BCW'(DATA_WIDTH - 1);

  spi_tx_state_t         r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic                  r_sclk, w_sclk_next;
  logic                  r_mosi, w_mosi_next;
  logic                  r_cs_n, w_cs_n_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;

  logic                  w_tick;
  logic                  w_div_clear;
  logic [DATA_WIDTH-1:0] w_rotated;
  logic                  w_first_bit;
  logic                  w_next_bit;

  // The divider free-runs from the start of LEAD. Its ticks mark every phase
  // boundary of the frame.
  assign w_div_clear = (r_state == S_IDLE) || (r_state == S_DONE);

  spi_half_tick #(
    .HALF (CLK_DIV)
  ) u_half_tick (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_div_clear),
    .o_tick    (w_tick)
  );

  // The outgoing bit always sits at one end of the shift register. Rotating
  // rather than shifting keeps every register bit live.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_rotated   = {r_shift[DATA_WIDTH-2:0], r_shift[DATA_WIDTH-1]};
      assign w_first_bit = i_data[DATA_WIDTH-1];
      assign w_next_bit  = r_shift[DATA_WIDTH-2];
    end else begin : g_lsb_first
      assign w_rotated   = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
      assign w_first_bit = i_data[0];
      assign w_next_bit  = r_shift[1];
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= SPI_CPOL;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_sclk    <= w_sclk_next;
      r_mosi    <= w_mosi_next;
      r_cs_n    <= w_cs_n_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_sclk_next    = r_sclk;
    w_mosi_next    = r_mosi;
    w_cs_n_next    = r_cs_n;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;

    case (r_state)
      // DONE behaves like IDLE for acceptance so that back-to-back frames
      // get exactly one CS-high cycle between them.
      S_IDLE, S_DONE: begin
        w_state_next = S_IDLE;
        w_sclk_next  = SPI_CPOL;
        w_mosi_next  = 1'b0;
        w_cs_n_next  = 1'b1;
        w_busy_next  = 1'b0;
        if (i_send) begin
          w_state_next   = S_LEAD;
          w_shift_next   = i_data;
          w_bit_cnt_next = '0;
          w_mosi_next    = w_first_bit;
          w_cs_n_next    = 1'b0;
          w_busy_next    = 1'b1;
        end
      end

      S_LEAD: begin
        if (w_tick) begin
          w_state_next = S_SHIFT;
          w_sclk_next  = ~SPI_CPOL;
        end
      end

      S_SHIFT: begin
        if (w_tick) begin
          if (r_sclk != SPI_CPOL) begin
            // Falling edge: advance MOSI, except after the final bit. The
            // final bit stays on the line through TRAIL.
            w_sclk_next = SPI_CPOL;
            if (r_bit_cnt == C_LAST_BIT) begin
              w_state_next = S_TRAIL;
            end else begin
              w_shift_next   = w_rotated;
              w_mosi_next    = w_next_bit;
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_sclk_next = ~SPI_CPOL;
          end
        end
      end

      S_TRAIL: begin
        if (w_tick) begin
          w_state_next = S_DONE;
          w_mosi_next  = 1'b0;
          w_cs_n_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_cs_n = r_cs_n;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_spi_tx_shifter
// Purpose : Self-checking bench for spi_tx_shifter. dut0 uses the default
//           parameters. dut1 uses CLK_DIV=1 and LSB-first. Each frame is
//           checked cycle by cycle against a phase-based reference model.
//           MOSI values captured at SCLK rises are compared with the
//           expected bit order.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_tx_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [7:0] data;
  logic       sel;

  logic sclk0, mosi0, cs0, busy0, done0;
  logic sclk1, mosi1, cs1, busy1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_tx_shifter dut0 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_send    (send & ~sel),
    .i_data    (data),
    .o_sclk    (sclk0),
    .o_mosi    (mosi0),
    .o_cs_n    (cs0),
    .o_busy    (busy0),
    .o_done    (done0)
  );

  spi_tx_shifter #(
    .DATA_WIDTH (8),
    .CLK_DIV    (1),
    .MSB_FIRST  (1'b0)
  ) dut1 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_send    (send & sel),
    .i_data    (data),
    .o_sclk    (sclk1),
    .o_mosi    (mosi1),
    .o_cs_n    (cs1),
    .o_busy    (busy1),
    .o_done    (done1)
  );

  wire obs_sclk = sel ? sclk1 : sclk0;
  wire obs_mosi = sel ? mosi1 : mosi0;
  wire obs_cs   = sel ? cs1   : cs0;
  wire obs_busy = sel ? busy1 : busy0;
  wire obs_done = sel ? done1 : done0;

  // Protocol invariants checked on both instances every cycle.
  wire [1:0] v_sclk = {sclk1, sclk0};
  wire [1:0] v_mosi = {mosi1, mosi0};
  wire [1:0] v_cs   = {cs1, cs0};
  wire [1:0] v_done = {done1, done0};
  logic [1:0] p_sclk = '0;
  logic [1:0] p_mosi = '0;
  logic [1:0] p_done = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (p_sclk[i] && v_sclk[i] && (v_mosi[i] !== p_mosi[i])) begin
          bad++;
          $display("FAIL mosi_stable dut%0d: mosi=%b required=%b", i, v_mosi[i], p_mosi[i]);
        end
        total++;
        if (v_cs[i] && v_sclk[i]) begin
          bad++;
          $display("FAIL sclk_idle dut%0d: sclk=%b required=0 while cs_n=1", i, v_sclk[i]);
        end
        total++;
        if (p_done[i] && v_done[i]) begin
          bad++;
          $display("FAIL done_single dut%0d: done high on two consecutive cycles", i);
        end
      end
    end
    p_sclk <= v_sclk;
    p_mosi <= v_mosi;
    p_done <= v_done;
  end

  // Run one frame on the selected DUT. Cycle k is sampled on the negedge
  // after the k-th rising edge that follows acceptance. The model splits the
  // busy window into 2N+1 phases of H cycles. Phase 0 is CS setup. Odd
  // phases are SCLK-high bit periods. Phase 2N is CS hold.
  task automatic run_frame(input logic [7:0] d, input bit prestarted,
                           input int inj_cycle, input logic [7:0] inj_data,
                           input bit chain, input logic [7:0] chain_data,
                           input string name);
    int   h;
    int   n;
    int   last;
    int   ph;
    int   bi;
    bit   msb;
    logic [7:0] dv;
    logic exp_bits[8];
    logic got[$];
    logic prev_sclk;
    logic [4:0] e;
    logic [4:0] o;
    h    = sel ? 1 : 2;
    msb  = !sel;
    n    = 8;
    last = (2 * n + 1) * h;
    dv   = d;
    for (int i = 0; i < n; i++) exp_bits[i] = msb ? dv[n-1-i] : dv[i];
    if (!prestarted) begin
      @(negedge clk);
      send = 1'b1;
      data = d;
    end
    prev_sclk = 1'b0;
    for (int k = 1; k <= last + 1 + (chain ? 0 : 1); k++) begin
      @(negedge clk);
      send = 1'b0;
      data = 8'($urandom);
      if (k <= last) begin
        ph = (k - 1) / h;
        bi = ph / 2;
        if (bi > n - 1) bi = n - 1;
        // {sclk, mosi, cs_n, busy, done}
        e = {((ph % 2) == 1) && (ph < 2 * n), exp_bits[bi], 1'b0, 1'b1, 1'b0};
      end else begin
        e = {1'b0, 1'b0, 1'b1, 1'b0, (k == last + 1)};
      end
      o = {obs_sclk, obs_mosi, obs_cs, obs_busy, obs_done};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: sclk,mosi,cs_n,busy,done=%b required=%b", name, k, o, e);
      end
      if (obs_sclk && !prev_sclk) got.push_back(obs_mosi);
      prev_sclk = obs_sclk;
      if (k == inj_cycle) begin
        send = 1'b1;
        data = inj_data;
      end
      if (chain && k == last + 1) begin
        send = 1'b1;
        data = chain_data;
      end
    end
    total++;
    if (got.size() !== n) begin
      bad++;
      $display("FAIL %s rises: count=%0d required=%0d", name, got.size(), n);
    end
    for (int i = 0; i < got.size() && i < n; i++) begin
      total++;
      if (got[i] !== exp_bits[i]) begin
        bad++;
        $display("FAIL %s bit%0d: mosi=%b required=%b", name, i, got[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    send  = 1'b0;
    data  = 8'h00;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cs0, sclk0, mosi0, busy0, done0} !== 5'b10000) begin
      bad++;
      $display("FAIL reset dut0: cs_n,sclk,mosi,busy,done=%b required=10000",
               {cs0, sclk0, mosi0, busy0, done0});
    end
    total++;
    if ({cs1, sclk1, mosi1, busy1, done1} !== 5'b10000) begin
      bad++;
      $display("FAIL reset dut1: cs_n,sclk,mosi,busy,done=%b required=10000",
               {cs1, sclk1, mosi1, busy1, done1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    sel = 1'b0;
    run_frame(8'hA5, 1'b0, 0, 8'h00, 1'b0, 8'h00, "single_a5");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_frame(8'($urandom), 1'b0, 0, 8'h00, 1'b1, 8'h3C, "b2b_first");
    run_frame(8'h3C, 1'b1, 0, 8'h00, 1'b0, 8'h00, "b2b_3c");
  endtask

  task automatic test_send_while_busy();
    sel = 1'b0;
    run_frame(8'h00, 1'b0, 10, 8'hFF, 1'b0, 8'h00, "busy_ignore");
  endtask

  task automatic test_reset_midframe();
    sel = 1'b0;
    @(negedge clk);
    send = 1'b1;
    data = 8'($urandom);
    @(negedge clk);
    send = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cs0, sclk0, busy0, done0, mosi0} !== 5'b10000) begin
      bad++;
      $display("FAIL midframe_reset: cs_n,sclk,busy,done,mosi=%b required=10000",
               {cs0, sclk0, busy0, done0, mosi0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h81, 1'b0, 0, 8'h00, 1'b0, 8'h00, "after_reset_81");
  endtask

  task automatic test_random(input logic dsel, input int frames);
    bit         pre;
    bit         chain;
    logic [7:0] d;
    logic [7:0] nd;
    int         inj;
    sel = dsel;
    pre = 1'b0;
    d   = 8'($urandom);
    for (int f = 0; f < frames; f++) begin
      chain = (f < frames - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      nd    = 8'($urandom);
      inj   = $urandom_range(1, dsel ? 17 : 34);
      run_frame(d, pre, inj, 8'($urandom), chain, nd, dsel ? "rand_div1" : "rand_def");
      pre = chain;
      d   = chain ? nd : 8'($urandom);
    end
  endtask

  task automatic test_div1_lsb();
    sel = 1'b1;
    run_frame(8'h01, 1'b0, 0, 8'h00, 1'b0, 8'h00, "div1_lsb_01");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_send_while_busy();
    test_reset_midframe();
    test_random(1'b0, 6);
    test_div1_lsb();
    test_random(1'b1, 6);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
